// File: rtl/ifetch_pkg.sv
// Shared defaults, the NOP encoding and the prefetch-queue entry layout
// for the instruction fetch queue.
package ifetch_pkg;

  localparam int INS_W_DEF     = 8;
  localparam int ADDR_W_DEF    = 8;
  localparam int MEM_DEPTH_DEF = 16;
  localparam int Q_DEPTH_DEF   = 4;
  localparam int RESET_PC_DEF  = 0;

  localparam logic [INS_W_DEF-1:0] NOP = '0;

  // Entry layout at the default widths; the top re-declares it with its own widths.
  typedef struct packed {
    logic [INS_W_DEF-1:0]  code;
    logic [ADDR_W_DEF-1:0] pc;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO with a flush that empties it in one edge.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush && (count != FULL_COUNT);
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: program memory with a synchronous read,
// fetch PC with redirect, and a prefetch queue presented as a valid/ready head.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int INS_W     = INS_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int Q_DEPTH   = Q_DEPTH_DEF,
  parameter int RESET_PC  = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INS_W-1:0]  ins_code,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              addr_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INS_W-1:0]  wr_data
);

  localparam int CW     = $clog2(Q_DEPTH) + 1;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(RESET_PC);
  localparam logic [CW-1:0]     Q_LIMIT   = CW'(Q_DEPTH);

  typedef struct packed {
    logic [INS_W-1:0]  code;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  // Handshake: the head transfers on a cycle where ins_valid && ins_ready;
  // while ins_valid is high and ins_ready low the head is held unchanged.

  logic [INS_W-1:0]  mem [MEM_DEPTH];
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] rd_pc;
  logic [INS_W-1:0]  rd_code;
  logic              rd_valid;
  logic [CW-1:0]     q_count;
  logic              issue;
  logic              push;
  logic              pop;
  logic              redirect_bad;
  logic              wr_ok;
  entry_t            push_entry;
  entry_t            head_entry;

  // Occupancy counts the read already in flight so the queue can never overflow.
  assign issue        = !redirect_valid && ((q_count + CW'(rd_valid)) < Q_LIMIT);
  assign push         = rd_valid && !redirect_valid;
  assign pop          = ins_valid && ins_ready;
  assign redirect_bad = ({1'b0, redirect_pc} >= MEM_LIMIT);
  assign wr_ok        = wr_en && !reset && ({1'b0, wr_addr} < MEM_LIMIT);
  assign next_pc      = (fetch_pc == LAST_PC) ? '0 : fetch_pc + 1'b1;

  assign push_entry.code = rd_code;
  assign push_entry.pc   = rd_pc;

  // Write and read share an edge, so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr[MEM_AW-1:0]] <= wr_data;
    if (issue) rd_code <= mem[fetch_pc[MEM_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= START_PC;
      rd_pc    <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= redirect_valid && redirect_bad;
      if (redirect_valid) begin
        fetch_pc <= redirect_bad ? '0 : redirect_pc;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= issue;
        if (issue) begin
          rd_pc    <= fetch_pc;
          fetch_pc <= next_pc;
        end
      end
    end
  end

  ifetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (Q_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (q_count)
  );

  assign ins_valid = (q_count != '0);
  assign ins_code  = ins_valid ? head_entry.code : INS_W'(NOP);
  assign ins_pc    = ins_valid ? head_entry.pc : '0;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- INS_W, 8, instruction width in bits.
- ADDR_W, 8, PC width in bits.
- MEM_DEPTH, 16, number of instruction words; MEM_DEPTH <= 2**ADDR_W.
- Q_DEPTH, 4, prefetch queue entries; power of 2, >= 2.
- RESET_PC, 0, fetch address after reset.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, input, 1, rising-edge clock.
- reset, input, 1, reset, synchronous, active-high.
- redirect_valid, input, 1, jump/branch taken this cycle.
- redirect_pc, input, ADDR_W, jump target.
- ins_valid, output, 1, queue head holds an instruction.
- ins_ready, input, 1, consumer accepts the head.
- ins_code, output, INS_W, head instruction.
- ins_pc, output, ADDR_W, address of the head instruction.
- addr_err, output, 1, one-cycle pulse on an out-of-range redirect.
- wr_en, input, 1, program-load write strobe.
- wr_addr, input, ADDR_W, program-load address.
- wr_data, input, INS_W, program-load data.

Function
REQ-003 Instruction memory SHALL be MEM_DEPTH x INS_W with a synchronous read: address issued in cycle C, data registered at the end of C, data pushed into the queue at the end of C+1.
REQ-004 A fetch SHALL issue in a cycle only when (queue count + in-flight reads) < Q_DEPTH; each issue reads mem[fetch_pc] and advances fetch_pc by 1.
REQ-005 fetch_pc SHALL wrap from MEM_DEPTH-1 to 0.
REQ-006 Each queue entry SHALL carry {ins_code, ins_pc}; ins_valid SHALL equal (count != 0).
REQ-007 The head SHALL pop on ins_valid && ins_ready.
REQ-008 While ins_valid=1 and ins_ready=0, ins_code and ins_pc SHALL remain stable.
REQ-009 Push and pop in the same cycle SHALL leave count unchanged.
REQ-010 Throughput SHALL be one instruction per cycle in steady state with ins_ready held at 1.
REQ-011 From reset deassertion, the first ins_valid=1 SHALL occur in the 2nd cycle after release, with ins_code=mem[RESET_PC] and ins_pc=RESET_PC.
REQ-012 A redirect_valid sampled in cycle N SHALL have the following effects:
- A handshake in cycle N completes normally.
- All other queue entries are flushed.
- Any in-flight read is discarded.
- fetch_pc becomes redirect_pc in N+1.
- ins_valid is 0 in N+1 and N+2.
- The target instruction is presented in N+3.
REQ-013 A redirect SHALL take priority over an issue or push in the same cycle.
REQ-014 Back-to-back redirects SHALL each restart per REQ-012; only the last one takes effect.
REQ-015 redirect_pc >= MEM_DEPTH SHALL set fetch_pc to 0, pulse addr_err high for cycle N+1, and otherwise behave per REQ-012.
REQ-016 wr_en=1 SHALL write mem[wr_addr] at the clock edge; writes with wr_addr >= MEM_DEPTH SHALL be ignored.
REQ-017 A same-cycle read and write to one address SHALL return the old data.
REQ-018 Already-queued entries SHALL NOT be updated by later writes.

Reset
REQ-019 On reset=1 at a clock edge, the block SHALL set:
- fetch_pc = RESET_PC.
- count = 0.
- In-flight read killed.
- ins_valid = 0, ins_code = 0, ins_pc = 0, addr_err = 0.
REQ-020 Memory contents SHALL be retained across reset.
REQ-021 reset SHALL override redirect_valid, wr_en and ins_ready in the same cycle.
REQ-022 Reset mid-stream SHALL discard all queued and in-flight instructions.

Structure
REQ-023 Package ifetch_pkg SHALL hold:
- Parameter defaults.
- The NOP constant (all zeros).
- The queue-entry struct {code, pc}.
REQ-024 The queue SHALL be sub-module ifetch_fifo (synchronous, flush input, count output); memory, PC and issue control SHALL reside in ifetch_queue.

Verification
REQ-025 Load mem[0..6]=1B,53,5A,C1,1B,5B,58; release reset with ins_ready=1 -> ins_valid first in cycle 2; codes 1B,53,5A,C1,1B,5B,58 on consecutive cycles with ins_pc 0..6.
REQ-026 Hold ins_ready=0 for 10 cycles -> count saturates at 4; head stays 1B/pc 0; only 4 issues occur; raising ins_ready resumes at 1 per cycle with no loss or duplication.
REQ-027 Redirect to pc 3 while the queue is full -> ins_valid=0 for 2 cycles, then C1/pc 3, 1B/pc 4 in order; no stale 5A appears.
REQ-028 MEM_DEPTH=7, free-run -> after pc 6 (58) the next ins_pc is 0 (1B); redirect_pc=9 -> addr_err pulses 1 cycle and the stream restarts at pc 0.
REQ-029 Assert reset while 3 entries are queued and a read is in flight -> next cycle ins_valid=0, count=0; after release the stream restarts at RESET_PC with memory intact.
REQ-030 Write mem[4]=AA in the same cycle pc 4 is issued -> old 1B delivered; after a redirect to 4 -> AA delivered.
